// File: rtl/imuldiv_mul_iter_param_pkg.sv
// Shared constants for the iterative imuldiv units.
// state_t   : sequencing states, encoded IDLE=0, CALC=1, SIGN=2, DONE=3.
//             The iterative divider is expected to reuse this encoding.
// mux_sel_t : operand register update select (hold / load / shift).
package imuldiv_mul_iter_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_LOAD  = 2'd1,
    SEL_SHIFT = 2'd2
  } mux_sel_t;

endpackage

// File: rtl/imuldiv_mul_iter_param_ctrl.sv
// Control for the iterative shift-add multiplier: FSM and iteration counter.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   mulreq_val/rdy        : request handshake (rdy only in IDLE)
//   mulresp_val/rdy       : response handshake (val only in DONE)
//   b_is_zero, b_lsb      : multiplier register status from the datapath
//   a_mux_sel, b_mux_sel  : operand register update select
//   result_en             : result register write enable
//   add_en                : accumulate a into result (else clear) when writing
//   sign_en               : apply conditional negation to result when writing
module imuldiv_mul_iter_param_ctrl
  import imuldiv_mul_iter_param_pkg::*;
#(
  parameter int unsigned W          = 32,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     mulreq_val,
  output logic     mulreq_rdy,
  output logic     mulresp_val,
  input  logic     mulresp_rdy,
  input  logic     b_is_zero,
  input  logic     b_lsb,
  output mux_sel_t a_mux_sel,
  output mux_sel_t b_mux_sel,
  output logic     result_en,
  output logic     add_en,
  output logic     sign_en
);

  localparam int unsigned   CW   = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_count;
  logic          w_fire;
  logic          w_early;
  logic          w_step;

  assign w_fire  = mulreq_val && (r_state == ST_IDLE);
  // With early exit, a zero multiplier ends CALC without touching the datapath.
  assign w_early = EARLY_EXIT && b_is_zero;
  assign w_step  = (r_state == ST_CALC) && !w_early;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_fire)
        r_count <= '0;
      else if (w_step)
        r_count <= r_count + ONE;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_fire) w_next = ST_CALC;
      ST_CALC: if (w_early || (r_count == LAST)) w_next = ST_SIGN;
      ST_SIGN: w_next = ST_DONE;
      ST_DONE: if (mulresp_rdy) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mulreq_rdy  = 1'b0;
    mulresp_val = 1'b0;
    a_mux_sel   = SEL_HOLD;
    b_mux_sel   = SEL_HOLD;
    result_en   = 1'b0;
    add_en      = 1'b0;
    sign_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        mulreq_rdy = 1'b1;
        if (w_fire) begin
          a_mux_sel = SEL_LOAD;
          b_mux_sel = SEL_LOAD;
          result_en = 1'b1;
        end
      end
      ST_CALC: begin
        if (w_step) begin
          a_mux_sel = SEL_SHIFT;
          b_mux_sel = SEL_SHIFT;
          result_en = b_lsb;
          add_en    = b_lsb;
        end
      end
      ST_SIGN: begin
        result_en = 1'b1;
        sign_en   = 1'b1;
      end
      ST_DONE: mulresp_val = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/imuldiv_mul_iter_param.sv
// Parametrised iterative shift-add multiplier (W x W -> 2W), signed or
// unsigned per request, with optional early termination on zero multiplier.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   mulreq_msg_a/b             : multiplicand / multiplier (W bits)
//   mulreq_msg_signed          : 1 = two's-complement operands and result
//   mulreq_val/rdy             : request handshake
//   mulresp_msg_result         : 2W-bit product, stable while in DONE
//   mulresp_val/rdy            : response handshake
module imuldiv_mul_iter_param
  import imuldiv_mul_iter_param_pkg::*;
#(
  parameter int unsigned W          = 32,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [W-1:0]   mulreq_msg_a,
  input  logic [W-1:0]   mulreq_msg_b,
  input  logic           mulreq_msg_signed,
  input  logic           mulreq_val,
  output logic           mulreq_rdy,
  output logic [2*W-1:0] mulresp_msg_result,
  output logic           mulresp_val,
  input  logic           mulresp_rdy
);

  localparam logic [W-1:0]   ONE_W  = W'(1);
  localparam logic [2*W-1:0] ONE_2W = (2*W)'(1);

  logic [2*W-1:0] r_a;
  logic [W-1:0]   r_b;
  logic [2*W-1:0] r_result;
  logic           r_neg;

  logic [W-1:0]   w_abs_a;
  logic [W-1:0]   w_abs_b;
  logic           w_neg_a;
  logic           w_neg_b;
  mux_sel_t       w_a_mux_sel;
  mux_sel_t       w_b_mux_sel;
  logic           w_result_en;
  logic           w_add_en;
  logic           w_sign_en;
  logic           w_b_is_zero;
  logic           w_b_lsb;

  // Magnitudes; -2^(W-1) maps to 2^(W-1), which still fits in W unsigned bits.
  assign w_neg_a = mulreq_msg_signed && mulreq_msg_a[W-1];
  assign w_neg_b = mulreq_msg_signed && mulreq_msg_b[W-1];
  assign w_abs_a = w_neg_a ? (~mulreq_msg_a + ONE_W) : mulreq_msg_a;
  assign w_abs_b = w_neg_b ? (~mulreq_msg_b + ONE_W) : mulreq_msg_b;

  assign w_b_is_zero        = (r_b == '0);
  assign w_b_lsb            = r_b[0];
  assign mulresp_msg_result = r_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_neg    <= 1'b0;
    end else begin
      case (w_a_mux_sel)
        SEL_LOAD: begin
          r_a   <= {{W{1'b0}}, w_abs_a};
          r_neg <= w_neg_a ^ w_neg_b;
        end
        SEL_SHIFT: r_a <= r_a << 1;
        default: ;
      endcase
      case (w_b_mux_sel)
        SEL_LOAD:  r_b <= w_abs_b;
        SEL_SHIFT: r_b <= r_b >> 1;
        default: ;
      endcase
      // A write that is neither sign nor add is the clear on request accept.
      if (w_result_en) begin
        if (w_sign_en)
          r_result <= r_neg ? (~r_result + ONE_2W) : r_result;
        else if (w_add_en)
          r_result <= r_result + r_a;
        else
          r_result <= '0;
      end
    end
  end

  imuldiv_mul_iter_param_ctrl #(
    .W          (W),
    .EARLY_EXIT (EARLY_EXIT)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .mulreq_val  (mulreq_val),
    .mulreq_rdy  (mulreq_rdy),
    .mulresp_val (mulresp_val),
    .mulresp_rdy (mulresp_rdy),
    .b_is_zero   (w_b_is_zero),
    .b_lsb       (w_b_lsb),
    .a_mux_sel   (w_a_mux_sel),
    .b_mux_sel   (w_b_mux_sel),
    .result_en   (w_result_en),
    .add_en      (w_add_en),
    .sign_en     (w_sign_en)
  );

endmodule

// File: tb/tb_imuldiv_mul_iter_param.sv
// Bench for imuldiv_mul_iter_param: three instances
//   u0: W=32, fixed latency;  u1: W=32, early exit;  u2: W=8, early exit.
// Expected products come from plain 64-bit modular multiplication of the
// sign/zero-extended operands; expected latency from the timing rules.
module tb_imuldiv_mul_iter_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] a0, b0, a1, b1;
  logic [7:0]  a2, b2;
  logic        s0, s1, s2, v0, v1, v2;
  logic        qr0, qr1, qr2, rv0, rv1, rv2, rr0, rr1, rr2;
  logic [63:0] res0, res1;
  logic [15:0] res2;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  imuldiv_mul_iter_param #(.W(32), .EARLY_EXIT(1'b0)) u0 (
    .clk(clk), .reset(reset), .mulreq_msg_a(a0), .mulreq_msg_b(b0),
    .mulreq_msg_signed(s0), .mulreq_val(v0), .mulreq_rdy(qr0),
    .mulresp_msg_result(res0), .mulresp_val(rv0), .mulresp_rdy(rr0));

  imuldiv_mul_iter_param #(.W(32), .EARLY_EXIT(1'b1)) u1 (
    .clk(clk), .reset(reset), .mulreq_msg_a(a1), .mulreq_msg_b(b1),
    .mulreq_msg_signed(s1), .mulreq_val(v1), .mulreq_rdy(qr1),
    .mulresp_msg_result(res1), .mulresp_val(rv1), .mulresp_rdy(rr1));

  imuldiv_mul_iter_param #(.W(8), .EARLY_EXIT(1'b1)) u2 (
    .clk(clk), .reset(reset), .mulreq_msg_a(a2), .mulreq_msg_b(b2),
    .mulreq_msg_signed(s2), .mulreq_val(v2), .mulreq_rdy(qr2),
    .mulresp_msg_result(res2), .mulresp_val(rv2), .mulresp_rdy(rr2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int width_of(input int inst);
    return (inst == 2) ? 8 : 32;
  endfunction

  function automatic logic [63:0] ref_mul(input int w, input logic sg,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mw, m2, ea, eb;
    mw = (64'd1 << w) - 64'd1;
    m2 = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    ea = {32'd0, a} & mw;
    eb = {32'd0, b} & mw;
    if (sg && ea[w-1]) ea = ea | ~mw;
    if (sg && eb[w-1]) eb = eb | ~mw;
    return (ea * eb) & m2;
  endfunction

  function automatic int exp_lat(input int w, input bit ee, input logic sg, input logic [31:0] b);
    logic [63:0] mw, ab;
    int k;
    if (!ee) return w + 2;
    mw = (64'd1 << w) - 64'd1;
    ab = {32'd0, b} & mw;
    if (sg && ab[w-1]) ab = ((64'd1 << w) - ab) & mw;
    k = 0;
    for (int i = 0; i < w; i++) if (ab[i]) k = i + 1;
    return (((k + 1) < w) ? (k + 1) : w) + 2;
  endfunction

  task automatic set_req(input int inst, input logic v, input logic sg,
                         input logic [31:0] a, input logic [31:0] b);
    case (inst)
      0:       begin v0 = v; s0 = sg; a0 = a; b0 = b; end
      1:       begin v1 = v; s1 = sg; a1 = a; b1 = b; end
      default: begin v2 = v; s2 = sg; a2 = a[7:0]; b2 = b[7:0]; end
    endcase
  endtask

  task automatic set_rr(input int inst, input logic r);
    case (inst)
      0:       rr0 = r;
      1:       rr1 = r;
      default: rr2 = r;
    endcase
  endtask

  task automatic get_outs(input int inst, output logic qr, output logic rv, output logic [63:0] res);
    case (inst)
      0:       begin qr = qr0; rv = rv0; res = res0; end
      1:       begin qr = qr1; rv = rv1; res = res1; end
      default: begin qr = qr2; rv = rv2; res = {48'd0, res2}; end
    endcase
  endtask

  // Called #1 after the fire edge (i.e. in cycle 1).
  task automatic wait_resp(input int inst, input int lat, input logic [63:0] exp, input string tag);
    logic qr, rv;
    logic [63:0] res;
    int cyc;
    cyc = 1;
    get_outs(inst, qr, rv, res);
    while (!rv && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      get_outs(inst, qr, rv, res);
    end
    check({tag, ".lat"}, 64'(cyc), 64'(lat));
    check({tag, ".res"}, res, exp);
  endtask

  task automatic wait_req_rdy(input int inst, input string tag);
    logic qr, rv;
    logic [63:0] res;
    int cyc;
    cyc = 0;
    get_outs(inst, qr, rv, res);
    while (!qr && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      get_outs(inst, qr, rv, res);
    end
    check({tag, ".reqrdy"}, {63'd0, qr}, 64'd1);
  endtask

  task automatic do_op(input int inst, input logic sg, input logic [31:0] a,
                       input logic [31:0] b, input string tag);
    logic qr, rv;
    logic [63:0] res;
    int w;
    w = width_of(inst);
    set_rr(inst, 1'b1);
    wait_req_rdy(inst, tag);
    set_req(inst, 1'b1, sg, a, b);
    @(posedge clk); #1;
    set_req(inst, 1'b0, 1'b0, '0, '0);
    wait_resp(inst, exp_lat(w, inst != 0, sg, b), ref_mul(w, sg, a, b), tag);
    @(posedge clk); #1;
    get_outs(inst, qr, rv, res);
    check({tag, ".val_after"}, {63'd0, rv}, 64'd0);
  endtask

  initial begin
    logic qr, rv;
    logic [63:0] res, held;
    logic [31:0] ra, rb;
    logic rs;

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(i, 1'b0, 1'b0, '0, '0);
      set_rr(i, 1'b1);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      get_outs(i, qr, rv, res);
      check($sformatf("reset%0d.reqrdy", i), {63'd0, qr}, 64'd1);
      check($sformatf("reset%0d.val", i), {63'd0, rv}, 64'd0);
      check($sformatf("reset%0d.res", i), res, 64'd0);
    end
    reset = 1'b0;

    // Fixed-latency instance
    do_op(0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "u_maxmax");
    check("u_maxmax.const", ref_mul(32, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    do_op(0, 1'b1, 32'hFFFF_FFF9, 32'd6, "s_m7x6");
    do_op(0, 1'b1, 32'h8000_0000, 32'h8000_0000, "s_minmin");
    do_op(0, 1'b0, 32'h8000_0000, 32'd0, "u_fixed_b0");

    // Early-exit instance
    do_op(1, 1'b0, 32'd77, 32'd0, "ee_b0");
    do_op(1, 1'b0, 32'd5, 32'd3, "ee_5x3");
    do_op(1, 1'b1, 32'd123, 32'hFFFF_FFFF, "ee_s_bm1");
    do_op(1, 1'b0, 32'd123, 32'hFFFF_FFFF, "ee_u_bmax");
    do_op(1, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, "ee_s_m1xmin");

    // Backpressure: hold DONE for 10 cycles, then back-to-back request
    set_rr(1, 1'b0);
    wait_req_rdy(1, "bp");
    set_req(1, 1'b1, 1'b0, 32'd1234, 32'd5678);
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, '0, '0);
    held = ref_mul(32, 1'b0, 32'd1234, 32'd5678);
    wait_resp(1, exp_lat(32, 1'b1, 1'b0, 32'd5678), held, "bp");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      get_outs(1, qr, rv, res);
      check($sformatf("bp.hold%0d.res", i), res, held);
      check($sformatf("bp.hold%0d.reqrdy", i), {63'd0, qr}, 64'd0);
      check($sformatf("bp.hold%0d.val", i), {63'd0, rv}, 64'd1);
    end
    set_rr(1, 1'b1);
    set_req(1, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'd9);
    @(posedge clk); #1;
    get_outs(1, qr, rv, res);
    check("bp.release.reqrdy", {63'd0, qr}, 64'd1);
    check("bp.release.val", {63'd0, rv}, 64'd0);
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, '0, '0);
    wait_resp(1, exp_lat(32, 1'b1, 1'b1, 32'd9), ref_mul(32, 1'b1, 32'hFFFF_FFFE, 32'd9), "bp.next");
    @(posedge clk); #1;

    // Reset during CALC cycle 10 on the fixed-latency instance
    wait_req_rdy(0, "rst");
    set_req(0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    get_outs(0, qr, rv, res);
    check("rst.reqrdy", {63'd0, qr}, 64'd1);
    check("rst.val", {63'd0, rv}, 64'd0);
    do_op(0, 1'b0, 32'd3, 32'd4, "rst.3x4");

    // Narrow instance
    do_op(2, 1'b1, 32'h80, 32'hFF, "w8_m128xm1");
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      // Bias some multipliers small so early exit is exercised at many depths.
      if ((n % 4) == 0) rb = rb & ((32'd1 << $urandom_range(0, 7)) - 32'd1);
      rs = 1'(n % 2);
      do_op(2, rs, ra, rb, $sformatf("w8_rand%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
